// File: rtl/cp0_exc_ctrl_if.sv
// cp0_exc_ctrl_if: M-stage pipeline <-> CP0 signal bundle
interface cp0_exc_ctrl_if;
    logic        valid_M;
    logic [31:0] PC_M;
    logic        BD_M;
    logic [4:0]  ExcCode_M;
    logic [5:0]  HWInt;
    logic [4:0]  cp0_addr;
    logic        cp0_we;
    logic [31:0] cp0_wd;
    logic        eret_M;
    logic [31:0] cp0_rd;
    logic [31:0] EPC;
    logic        IntReq;
    logic        flush;
    logic [31:0] redirect_pc;
    modport master (
        output valid_M, PC_M, BD_M, ExcCode_M, HWInt, cp0_addr, cp0_we, cp0_wd, eret_M,
        input  cp0_rd, EPC, IntReq, flush, redirect_pc
    );
    modport slave (
        input  valid_M, PC_M, BD_M, ExcCode_M, HWInt, cp0_addr, cp0_we, cp0_wd, eret_M,
        output cp0_rd, EPC, IntReq, flush, redirect_pc
    );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: CP0 registers plus exception/interrupt sequencing at the M stage
module cp0_exc_ctrl #(
    parameter logic [31:0] PRID      = 32'h2020_1215,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180
) (
    input logic clk,
    input logic reset,
    cp0_exc_ctrl_if.slave bus
);
    logic [5:0]  im, ip;
    logic        exl, ie, bd;
    logic [4:0]  exc_code;
    logic [31:0] epc, sr, cause, pc_al, epc_next;
    logic        int_pend, exc_pend, int_req;

    assign int_pend = |(bus.HWInt & im) & ie & ~exl;
    assign exc_pend = (bus.ExcCode_M != 5'd0) & ~exl;
    assign int_req  = bus.valid_M & (int_pend | exc_pend);
    assign sr       = {16'b0, im, 8'b0, exl, ie};
    assign cause    = {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};
    assign pc_al    = {bus.PC_M[31:2], 2'b00};
    assign epc_next = bus.BD_M ? pc_al - 32'd4 : pc_al;

    assign bus.IntReq      = int_req;
    assign bus.flush       = int_req | bus.eret_M;
    assign bus.EPC         = epc;
    assign bus.redirect_pc = int_req ? EXC_ENTRY : epc;

    always_comb begin
        bus.cp0_rd = bus.cp0_addr == 5'd12 ? sr :
                     bus.cp0_addr == 5'd13 ? cause :
                     bus.cp0_addr == 5'd14 ? epc :
                     bus.cp0_addr == 5'd15 ? PRID : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip       <= '0;
            exc_code <= '0;
            epc      <= '0;
        end else begin
            ip <= bus.HWInt;
            if (int_req) begin
                // interrupt outranks a synchronous exception; the mtc0 in M is cancelled
                exl      <= 1'b1;
                exc_code <= int_pend ? 5'd0 : bus.ExcCode_M;
                bd       <= bus.BD_M;
                epc      <= epc_next;
            end else begin
                if (bus.cp0_we && bus.cp0_addr == 5'd12) begin
                    im  <= bus.cp0_wd[15:10];
                    exl <= bus.cp0_wd[1];
                    ie  <= bus.cp0_wd[0];
                end
                if (bus.cp0_we && bus.cp0_addr == 5'd14)
                    epc <= {bus.cp0_wd[31:2], 2'b00};
                if (bus.eret_M)
                    exl <= 1'b0;
            end
        end
    end
endmodule
